// File: rtl/rom_sched_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rom_sched_pkg
// Description : Shared types and default widths for the ROM read scheduler:
//               scheduler state enum and the response-beat side-band struct.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_sched_pkg;

    localparam int C_DEF_NUM_REQ = 4;
    localparam int C_DEF_ADDR_W  = 3;
    localparam int C_DEF_DATA_W  = 8;
    localparam int C_DEF_LEN_W   = 3;

    // Requester id field sized for the largest supported NUM_REQ (8)
    localparam int C_ID_W_MAX    = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_e;

    // Side-band travelling alongside the ROM read latency
    typedef struct packed {
        logic                  valid;
        logic [C_ID_W_MAX-1:0] id;
        logic                  last;
    } rsp_beat_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first asserted
//               request at or above ptr, wrapping to the lowest request.
// Ports       : req [N]  - request vector
//               ptr [PW] - highest-priority index for this cycle
//               gnt [N]  - one-hot grant (all-zero when req is all-zero)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_hi;
    logic [N-1:0] w_sel;

    always_comb begin
        // Requests at or above the pointer take priority; if none, wrap and
        // take the lowest request overall. x & -x isolates the lowest set bit.
        w_mask = ~((N'(1) << ptr) - N'(1));
        w_hi   = req & w_mask;
        w_sel  = (|w_hi) ? w_hi : req;
        gnt    = w_sel & (~w_sel + N'(1));
    end

endmodule
`default_nettype wire

// File: rtl/rom_read_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rom_read_sched
// Description : Shares one registered single-port ROM among NUM_REQ
//               requesters. Round-robin arbitration, single or incrementing
//               (address-wrapping) bursts, tagged read responses.
// Ports       : clk_pi, rst_pi (async, active-high)
//               req_i/addr_i/len_i/gnt_o - requester side
//               rom_en_o/rom_addr_o/rom_data_i - ROM side (1-cycle latency)
//               rsp_valid_o/rsp_id_o/rsp_data_o/rsp_last_o - response beats
//               busy_o - burst active or beat in flight
// Revision    : 1.0 - initial release
// ============================================================================
module rom_read_sched
    import rom_sched_pkg::*;
#(
    parameter int NUM_REQ = C_DEF_NUM_REQ,
    parameter int ADDR_W  = C_DEF_ADDR_W,
    parameter int DATA_W  = C_DEF_DATA_W,
    parameter int LEN_W   = C_DEF_LEN_W
) (
    input  logic                        clk_pi,
    input  logic                        rst_pi,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
    input  logic [NUM_REQ*LEN_W-1:0]    len_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic                        rom_en_o,
    output logic [ADDR_W-1:0]           rom_addr_o,
    input  logic [DATA_W-1:0]           rom_data_i,
    output logic                        rsp_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id_o,
    output logic [DATA_W-1:0]           rsp_data_o,
    output logic                        rsp_last_o,
    output logic                        busy_o
);

    localparam int ID_W = $clog2(NUM_REQ);

    sched_state_e        state_q,      state_d;
    logic [ID_W-1:0]     rr_ptr_q,     rr_ptr_d;
    logic [ID_W-1:0]     cur_id_q,     cur_id_d;
    logic [LEN_W-1:0]    beats_left_q, beats_left_d;
    logic                rom_en_q,     rom_en_d;
    logic [ADDR_W-1:0]   rom_addr_q,   rom_addr_d;
    logic                iss_last_q,   iss_last_d;
    rsp_beat_t           s1_q,         s1_d;
    rsp_beat_t           s2_q,         s2_d;
    logic [DATA_W-1:0]   s2_data_q,    s2_data_d;

    logic [NUM_REQ-1:0]  w_arb_gnt;
    logic [ID_W-1:0]     w_gnt_idx;
    logic                w_xfer;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [LEN_W-1:0]    w_sel_len;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (ID_W)
    ) u_arb (
        .req (req_i),
        .ptr (rr_ptr_q),
        .gnt (w_arb_gnt)
    );

    // Grants only offered while idle; during reset state is IDLE and the
    // pointer is zero, so the grant still tracks req_i.
    assign gnt_o  = (state_q == IDLE) ? w_arb_gnt : '0;
    assign w_xfer = |(req_i & gnt_o);

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_gnt[i]) begin
                w_gnt_idx = ID_W'(i);
            end
        end
    end

    assign w_sel_addr = addr_i[w_gnt_idx*ADDR_W +: ADDR_W];
    assign w_sel_len  = len_i[w_gnt_idx*LEN_W +: LEN_W];

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cur_id_d     = cur_id_q;
        beats_left_d = beats_left_q;
        rom_en_d     = 1'b0;
        rom_addr_d   = rom_addr_q;
        iss_last_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_xfer) begin
                    rom_en_d     = 1'b1;
                    rom_addr_d   = w_sel_addr;
                    cur_id_d     = w_gnt_idx;
                    beats_left_d = w_sel_len;
                    rr_ptr_d     = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                                     : w_gnt_idx + ID_W'(1);
                    if (w_sel_len == '0) begin
                        iss_last_d = 1'b1;
                    end else begin
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                rom_en_d     = 1'b1;
                rom_addr_d   = rom_addr_q + ADDR_W'(1);
                beats_left_d = beats_left_q - LEN_W'(1);
                // Counter reaching zero on this edge marks the final beat
                if (beats_left_q == LEN_W'(1)) begin
                    iss_last_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Stage 1 lines up with the ROM's internal register; stage 2 meets
        // the ROM output and captures its data.
        s1_d.valid = rom_en_q;
        s1_d.id    = C_ID_W_MAX'(cur_id_q);
        s1_d.last  = iss_last_q;
        s2_d       = s1_q;
        s2_data_d  = s1_q.valid ? rom_data_i : s2_data_q;
    end

    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            cur_id_q     <= '0;
            beats_left_q <= '0;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= '0;
            iss_last_q   <= 1'b0;
            s1_q         <= '0;
            s2_q         <= '0;
            s2_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cur_id_q     <= cur_id_d;
            beats_left_q <= beats_left_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            iss_last_q   <= iss_last_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s2_data_q    <= s2_data_d;
        end
    end

    assign rom_en_o    = rom_en_q;
    assign rom_addr_o  = rom_addr_q;
    assign rsp_valid_o = s2_q.valid;
    assign rsp_id_o    = s2_q.id[ID_W-1:0];
    assign rsp_last_o  = s2_q.last;
    assign rsp_data_o  = s2_data_q;
    assign busy_o      = (state_q == BURST) | rom_en_q | s1_q.valid;

endmodule
`default_nettype wire

// File: tb/tb_rom_read_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rom_read_sched
// Description : Self-checking bench for rom_read_sched. A schedule-level model
//               predicts per-cycle grants, ROM issues and tagged responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_read_sched;

    localparam int N  = 4;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int LW = 3;

    logic              clk_pi = 1'b0;
    logic              rst_pi;
    logic [N-1:0]      req_i;
    logic [N*AW-1:0]   addr_i;
    logic [N*LW-1:0]   len_i;
    logic [N-1:0]      gnt_o;
    logic              rom_en_o;
    logic [AW-1:0]     rom_addr_o;
    logic [DW-1:0]     rom_data_i;
    logic              rsp_valid_o;
    logic [1:0]        rsp_id_o;
    logic [DW-1:0]     rsp_data_o;
    logic              rsp_last_o;
    logic              busy_o;

    always #5 clk_pi = ~clk_pi;

    rom_read_sched #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk_pi      (clk_pi),
        .rst_pi      (rst_pi),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .len_i       (len_i),
        .gnt_o       (gnt_o),
        .rom_en_o    (rom_en_o),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_last_o  (rsp_last_o),
        .busy_o      (busy_o)
    );

    // Registered 8x8 ROM
    logic [DW-1:0] rom_mem [8] = '{8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd6, 8'd9};
    always @(posedge clk_pi) if (rom_en_o) rom_data_i <= rom_mem[rom_addr_o];

    logic [AW-1:0] r_addr [N];
    logic [LW-1:0] r_len  [N];
    always_comb begin
        addr_i = '0;
        len_i  = '0;
        for (int k = 0; k < N; k++) begin
            addr_i[k*AW +: AW] = r_addr[k];
            len_i[k*LW +: LW]  = r_len[k];
        end
    end

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t         exp_rsp  [int];   // keyed by edge after which rsp_* shows it
    logic [AW-1:0] exp_addr [int];   // keyed by edge that issues the ROM read
    int            gnt_log  [$];
    int            cyc, rem, ptr, gk;
    bit            hold_req;
    int            checks, errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (p + i) % N;
            if (r[j]) return N'(1) << j;
        end
        return '0;
    endfunction

    // One clock: predict the grant for the coming edge, then check outputs.
    task automatic step();
        logic [N-1:0] g;
        #1;
        gk = -1;
        if (rem == 0) begin
            g = rr_pick(req_i, ptr);
            chk("gnt", 32'(gnt_o), 32'(g));
            for (int k = 0; k < N; k++) if (g[k]) gk = k;
            if (gk >= 0) begin
                gnt_log.push_back(gk);
                for (int n = 0; n <= int'(r_len[gk]); n++) begin
                    exp_addr[cyc+1+n] = AW'(int'(r_addr[gk]) + n);
                    exp_rsp[cyc+3+n]  = '{id: 2'(gk),
                                          d:  rom_mem[AW'(int'(r_addr[gk]) + n)],
                                          l:  (n == int'(r_len[gk]))};
                end
                rem = int'(r_len[gk]);
                ptr = (gk + 1) % N;
            end
        end else begin
            chk("gnt_in_burst", 32'(gnt_o), 32'd0);
            rem--;
        end
        @(posedge clk_pi);
        cyc++;
        #1;
        if (gk >= 0 && !hold_req) req_i[gk] = 1'b0;
        chk("rom_en", 32'(rom_en_o), 32'(exp_addr.exists(cyc)));
        if (exp_addr.exists(cyc)) chk("rom_addr", 32'(rom_addr_o), 32'(exp_addr[cyc]));
        chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_rsp.exists(cyc)));
        if (exp_rsp.exists(cyc)) begin
            chk("rsp_id",   32'(rsp_id_o),   32'(exp_rsp[cyc].id));
            chk("rsp_data", 32'(rsp_data_o), 32'(exp_rsp[cyc].d));
            chk("rsp_last", 32'(rsp_last_o), 32'(exp_rsp[cyc].l));
        end else begin
            chk("rsp_last_idle", 32'(rsp_last_o), 32'd0);
        end
        chk("busy", 32'(busy_o),
            32'((rem > 0) || exp_addr.exists(cyc) || exp_addr.exists(cyc-1)));
    endtask

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        checks = 0; errors = 0; cyc = 0; rem = 0; ptr = 0; hold_req = 0;
        for (int k = 0; k < N; k++) begin r_addr[k] = '0; r_len[k] = '0; end

        // Reset: outputs cleared, grant tracks requests, no transfer taken
        rst_pi = 1'b1;
        req_i  = 4'b0110;
        @(posedge clk_pi); #1;
        chk("rst_gnt",       32'(gnt_o),       32'h2);
        chk("rst_rom_en",    32'(rom_en_o),    32'd0);
        chk("rst_rom_addr",  32'(rom_addr_o),  32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_id",    32'(rsp_id_o),    32'd0);
        chk("rst_rsp_data",  32'(rsp_data_o),  32'd0);
        chk("rst_rsp_last",  32'(rsp_last_o),  32'd0);
        chk("rst_busy",      32'(busy_o),      32'd0);
        req_i = '0;
        @(negedge clk_pi);
        rst_pi = 1'b0;

        // Round-robin fairness with all requesters held
        for (int k = 0; k < N; k++) r_addr[k] = AW'($urandom_range(0, 7));
        hold_req = 1;
        req_i    = '1;
        repeat (5) step();
        hold_req = 0;
        req_i    = '0;
        for (int i = 0; i < 5; i++) chk("rr_order", 32'(gnt_log[i]), 32'(exp_order[i]));
        repeat (3) step();

        // Single read: addr 3 -> 16
        r_addr[0] = 3'd3; r_len[0] = 3'd0; req_i[0] = 1'b1;
        step(); step(); step();
        chk("single_data", 32'(rsp_data_o), 32'd16);
        chk("single_last", 32'(rsp_last_o), 32'd1);
        repeat (2) step();

        // Wrapping burst: 6,7,0,1 -> 6,9,2,4
        r_addr[1] = 3'd6; r_len[1] = 3'd3; req_i[1] = 1'b1;
        repeat (7) step();

        // Request raised while another requester's burst is in progress
        r_addr[2] = AW'($urandom_range(0, 7)); r_len[2] = 3'd2; req_i[2] = 1'b1;
        step(); step();
        r_addr[0] = 3'd5; r_len[0] = 3'd1; req_i[0] = 1'b1;
        repeat (7) step();

        // Randomized traffic; pending requests may also be withdrawn
        repeat (400) begin
            for (int k = 0; k < N; k++) begin
                if (!req_i[k] && $urandom_range(0, 3) == 0) begin
                    r_addr[k] = AW'($urandom_range(0, 7));
                    r_len[k]  = LW'($urandom_range(0, 7));
                    req_i[k]  = 1'b1;
                end else if (req_i[k] && $urandom_range(0, 15) == 0) begin
                    req_i[k] = 1'b0;
                end
            end
            step();
        end

        // Idle: nothing issued, nothing returned
        req_i = '0;
        repeat (20) step();

        // Reset during the second beat of a len-4 burst
        r_addr[0] = 3'd0; r_len[0] = 3'd4; req_i[0] = 1'b1;
        step(); step();
        #2;
        rst_pi = 1'b1;
        #1;
        chk("abort_rom_en",    32'(rom_en_o),    32'd0);
        chk("abort_rom_addr",  32'(rom_addr_o),  32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("abort_rsp_last",  32'(rsp_last_o),  32'd0);
        chk("abort_busy",      32'(busy_o),      32'd0);
        exp_addr.delete();
        exp_rsp.delete();
        rem = 0; ptr = 0;
        req_i = '0;
        @(posedge clk_pi); cyc++;
        @(posedge clk_pi); cyc++;
        @(negedge clk_pi);
        rst_pi = 1'b0;
        repeat (5) step();
        for (int k = 0; k < N; k++) r_len[k] = '0;
        req_i = '1;
        step();
        chk("tie_after_reset", 32'(gnt_log[gnt_log.size()-1]), 32'd0);
        req_i = '0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_read_sched.md
# rom_read_sched

Read scheduler that shares one 8-entry single-port ROM among `NUM_REQ` requesters. It round-robin arbitrates, issues single or incrementing-burst reads to the ROM, and returns tagged read data. It sits between the requester blocks and the ROM instance. It is the only driver of the ROM enable and address inputs.

## Interface
- `NUM_REQ`, default 4: number of requesters (2–8).
- `ADDR_W`, default 3: ROM address width.
- `DATA_W`, default 8: ROM data width.
- `LEN_W`, default 3: burst length field width. Beats per request = `len` + 1.
- `clk_pi`, in, 1: single clock. All state changes on the rising edge.
- `rst_pi`, in, 1: reset, asynchronous and active-high.
- `req_i`, in, `NUM_REQ`: request per requester. Held until granted.
- `addr_i`, in, `NUM_REQ*ADDR_W`: start address. Slice k belongs to requester k.
- `len_i`, in, `NUM_REQ*LEN_W`: burst length minus 1. Slice k belongs to requester k.
- `gnt_o`, out, `NUM_REQ`: one-hot grant, combinational. A transfer occurs when `req_i[k]` and `gnt_o[k]` are both high at a clock edge.
- `rom_en_o`, out, 1: ROM read enable, registered.
- `rom_addr_o`, out, `ADDR_W`: ROM address, registered.
- `rom_data_i`, in, `DATA_W`: ROM registered read data, 1-cycle latency from the `en`/`addr` edge.
- `rsp_valid_o`, out, 1: response beat valid, registered. No backpressure.
- `rsp_id_o`, out, `$clog2(NUM_REQ)`: requester index of the beat.
- `rsp_data_o`, out, `DATA_W`: read data.
- `rsp_last_o`, out, 1: final beat of a burst.
- `busy_o`, out, 1: high in BURST state or while any beat is in flight.

## Operation
- FSM states: IDLE and BURST.
- IDLE:
  - `gnt_o` is the round-robin winner among `req_i`, searching upward from pointer `rr_ptr` and wrapping.
  - `gnt_o` is all-zero if no request is pending.
- Transfer at edge T:
  - Register `rom_en_o`=1, `rom_addr_o`=`addr_i[k]`, `cur_id`=k, `beats_left`=`len_i[k]`.
  - Set `rr_ptr` = k+1 mod `NUM_REQ`.
  - If `len_i[k]`==0, stay IDLE and mark the beat last. Otherwise go to BURST.
- BURST:
  - `gnt_o` is all-zero.
  - Each edge issues `rom_addr_o` = previous + 1, wrapping modulo 2^`ADDR_W` (7→0).
  - `beats_left` decrements each edge. The beat issued when `beats_left` reaches 0 is last, and the FSM returns to IDLE on that edge.
- Any edge with no issue drives `rom_en_o`=0. `rom_addr_o` holds its last value.
- Response pipe:
  - Two register stages carry valid, id and last alongside the ROM latency.
  - Stage 2 also captures `rom_data_i`.
  - A beat issued at edge T appears on `rsp_*` after edge T+2.
- Back-to-back operation: issue rate is one beat per cycle, with no bubble between consecutive requests.
- Reset values:
  - Outputs: `rom_en_o`=0, `rom_addr_o`=0, all `rsp_*`=0, `busy_o`=0.
  - Internal state: IDLE, `rr_ptr`=0.
  - `gnt_o` follows `req_i` combinationally even during reset, but transfers are ignored while `rst_pi` is high.

## Timing
- Latency from transfer edge to first `rsp_valid_o`: 2 cycles. Beat n of a burst arrives at edge T+2+n.
- Simultaneous requests: exactly one grant per IDLE cycle. The other requests stay pending.
- Requesters may drop `req_i` at any time before the grant with no effect.
- `addr_i` and `len_i` are sampled only at the transfer edge.
- A request that arrives while in BURST is not granted until the cycle after the last beat issues.
- Reset mid-burst:
  - All state clears immediately.
  - In-flight beats are discarded and never appear on `rsp_valid_o`.
  - `rsp_last_o` is not emitted for the aborted burst.
- Burst length 8 with `ADDR_W`=3 reads all 8 locations once, wrapping from the start address.

## Structure
- Package `rom_sched_pkg` holds:
  - state enum `sched_state_e` {IDLE, BURST};
  - default width constants;
  - the response beat struct (valid, id, last).
- Sub-module `rr_arbiter`:
  - parameter `N`;
  - inputs `req`, `ptr`;
  - output one-hot `gnt`, combinational;
  - reused by other shared-resource controllers.

## Test plan
The bench uses the 8x8 ROM preloaded with 2, 4, 8, 16, 32, 64, 6, 9.
- Single read: req 0, addr 3, len 0 → `rom_en_o` for one cycle; 2 cycles later `rsp_valid_o`=1, id 0, data 16, last 1.
- Wrapping burst: req 1, addr 6, len 3 → beats 6, 9, 2, 4 on consecutive cycles, id 1, `rsp_last_o` only on 4; `gnt_o`=0 throughout BURST.
- Round-robin fairness: all 4 requesters held high with len 0 → grants in order 0, 1, 2, 3, 0, one per cycle, with no idle cycles on `rom_en_o`.
- Collision during burst: req 2 burst len 2 in progress, req 0 raised mid-burst → req 0 is granted in the cycle after the last beat of req 2 issues; its response follows with no gap.
- Reset mid-burst: assert `rst_pi` asynchronously during the second beat of a len 4 burst → all outputs 0 immediately; no further `rsp_valid_o`; after release, `rr_ptr` is back at 0 (requester 0 wins a full tie).
- Idle: no requests → `rom_en_o`, `rsp_valid_o` and `busy_o` stay 0 indefinitely.
